// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, port indices and FSM encoding for the memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 32;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_IOP = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_HOLD  = 2'd2
   } arb_state_t;

   function automatic logic other_port(input logic p);
      return ~p;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select for a fresh arbitration from IDLE.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the pointer port; else port 0 wins.
module arb_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_ptr,
   output logic o_vld,
   output logic o_win
);

   assign o_vld = i_req0 | i_req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_comb begin
      o_win = PORT_CPU;
      if (i_req0 && i_req1)
         o_win = i_ptr;
      else if (i_req1)
         o_win = PORT_IOP;
   end
`else
   logic w_unused_ptr;

   assign w_unused_ptr = i_ptr;

   always_comb begin
      o_win = PORT_CPU;
      if (i_req1 && !i_req0)
         o_win = PORT_IOP;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port single-memory arbiter with lock support for atomic sequences.
// Tie-break policy selected by MEM_ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_port_arbiter #(
   parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W,
   parameter int DATA_W = mem_port_arbiter_pkg::DATA_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req0,
   input  logic                req1,
   input  logic                wr0,
   input  logic                wr1,
   input  logic                lock0,
   input  logic                lock1,
   input  logic [32-ADDR_W:31] addr0,
   input  logic [32-ADDR_W:31] addr1,
   input  logic [0:DATA_W-1]   wdata0,
   input  logic [0:DATA_W-1]   wdata1,
   output logic                ack0,
   output logic                ack1,
   output logic [0:DATA_W-1]   rdata,
   output logic [32-ADDR_W:31] mem_address,
   output logic                mem_write_en,
   output logic [0:DATA_W-1]   mem_wdata,
   input  logic [0:DATA_W-1]   mem_rdata,
   output logic                owner,
   output logic                locked
);

   import mem_port_arbiter_pkg::*;

   arb_state_t          r_state;
   logic                r_owner;
   logic                r_locked;
   logic                r_ack0;
   logic                r_ack1;
   logic                r_we;
   logic                r_ptr;
   logic [32-ADDR_W:31] r_addr;
   logic [0:DATA_W-1]   r_wdata;

   logic                w_pick_vld;
   logic                w_pick_win;
   logic                w_own_req;
   logic                w_own_lock;
   logic                w_go;
   logic                w_win;
   logic                w_win_wr;
   logic [32-ADDR_W:31] w_win_addr;
   logic [0:DATA_W-1]   w_win_wdata;

   arb_pick u_pick (
      .i_req0 (req0),
      .i_req1 (req1),
      .i_ptr  (r_ptr),
      .o_vld  (w_pick_vld),
      .o_win  (w_pick_win)
   );

   assign w_own_req  = r_owner ? req1  : req0;
   assign w_own_lock = r_owner ? lock1 : lock0;

   // While locked only the owner may be granted again.
   always_comb begin
      w_go  = w_pick_vld;
      w_win = w_pick_win;
      if (r_state == ST_HOLD) begin
         w_go  = w_own_req;
         w_win = r_owner;
      end
   end

   assign w_win_wr    = w_win ? wr1    : wr0;
   assign w_win_addr  = w_win ? addr1  : addr0;
   assign w_win_wdata = w_win ? wdata1 : wdata0;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_owner  <= PORT_CPU;
         r_locked <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_we     <= 1'b0;
         r_ptr    <= PORT_CPU;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_we   <= 1'b0;
         unique case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (w_go) begin
                  r_state <= ST_GRANT;
                  r_owner <= w_win;
                  r_ack0  <= (w_win == PORT_CPU);
                  r_ack1  <= (w_win == PORT_IOP);
                  r_we    <= w_win_wr;
                  r_addr  <= w_win_addr;
                  r_wdata <= w_win_wdata;
               end
            end
            ST_GRANT: begin
               r_ptr <= other_port(r_owner);
               if (w_own_lock) begin
                  r_locked <= 1'b1;
                  r_state  <= ST_HOLD;
               end else begin
                  r_locked <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Gating with reset kills the write and ack of an interrupted grant.
   assign ack0         = r_ack0 & ~reset;
   assign ack1         = r_ack1 & ~reset;
   assign mem_write_en = r_we & ~reset;
   assign mem_address  = r_addr;
   assign mem_wdata    = r_wdata;
   assign rdata        = mem_rdata;
   assign owner        = r_owner;
   assign locked       = r_locked;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model, directed and random traffic.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
   localparam logic [3:0] CONT_EXP = 4'b0101;
`else
   localparam bit RR = 1'b0;
   localparam logic [3:0] CONT_EXP = 4'b0000;
`endif
   localparam int MEM_N = 131072;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic req0 = 0, req1 = 0, wr0 = 0, wr1 = 0, lock0 = 0, lock1 = 0;
   logic [15:31] addr0 = '0, addr1 = '0;
   logic [0:31]  wdata0 = '0, wdata1 = '0;
   logic ack0, ack1, mem_write_en, owner, locked;
   logic [0:31]  rdata, mem_wdata, mem_rdata;
   logic [15:31] mem_address;

   logic [31:0] ram    [0:MEM_N-1];
   logic [31:0] shadow [0:MEM_N-1];

   assign mem_rdata = ram[mem_address];

   always #5 clock = ~clock;

   mem_port_arbiter dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata),
      .mem_address(mem_address), .mem_write_en(mem_write_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .owner(owner), .locked(locked)
   );

   int ntests = 0;
   int nfail  = 0;

   // model: one grant cycle at a time, with a lock holder and tie pointer
   bit          m_gnt, m_owner, m_we, m_glock, m_locked, m_pref;
   logic [16:0] m_addr;
   logic [31:0] m_wdata;

   logic sa0, sa1, s_we, s_locked;
   logic [31:0] s_rdata;
   logic p_we;
   logic [16:0] p_a;
   logic [31:0] p_d;
   bit log_en = 0;
   int ack_log[$];
   int a1_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int w;
      w = -1;
      if (reset) begin
         m_gnt = 0; m_owner = 0; m_we = 0; m_glock = 0;
         m_locked = 0; m_pref = 0; m_addr = '0; m_wdata = '0;
      end else if (m_gnt) begin
         if (m_we) shadow[m_addr] = m_wdata;
         m_locked = m_glock;
         m_pref   = !m_owner;
         m_gnt    = 0;
      end else begin
         if (m_locked) begin
            if (m_owner ? req1 : req0) w = int'(m_owner);
         end else if (req0 && req1) w = RR ? int'(m_pref) : 0;
         else if (req0) w = 0;
         else if (req1) w = 1;
         if (w >= 0) begin
            m_gnt   = 1;
            m_owner = (w == 1);
            m_we    = m_owner ? wr1 : wr0;
            m_glock = m_owner ? lock1 : lock0;
            m_addr  = m_owner ? addr1 : addr0;
            m_wdata = m_owner ? wdata1 : wdata0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("ack0",   ack0,         m_gnt && !m_owner && !reset);
      chk("ack1",   ack1,         m_gnt && m_owner && !reset);
      chk("we",     mem_write_en, m_gnt && m_we && !reset);
      chk("addr",   mem_address,  m_addr);
      chk("wdata",  mem_wdata,    m_wdata);
      chk("locked", locked,       m_locked);
      chk("owner",  owner,        m_owner);
      if (m_gnt && !m_we && !reset)
         chk("rdata", rdata, shadow[m_addr]);
   endtask

   task automatic cycle();
      @(negedge clock);
      check_outputs();
      sa0 = ack0; sa1 = ack1; s_we = mem_write_en;
      s_rdata = rdata; s_locked = locked;
      p_we = mem_write_en; p_a = mem_address; p_d = mem_wdata;
      if (ack1 === 1'b1) a1_cnt++;
      if (log_en) begin
         if (ack0 === 1'b1) ack_log.push_back(0);
         if (ack1 === 1'b1) ack_log.push_back(1);
      end
      @(posedge clock);
      if (p_we === 1'b1) ram[p_a] = p_d;
      model_step();
      #1;
   endtask

   task automatic wait_ack(input int p, input int budget, input string nm);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(p == 1 ? sa1 : sa0) && n < budget);
      chk({"ack_wait_", nm}, p == 1 ? sa1 : sa0, 1);
   endtask

   initial begin
      logic [3:0]  order;
      logic [2:0]  lk_order;
      logic [31:0] old;
      logic        held;
      int          n, a1_before;

      for (int i = 0; i < MEM_N; i++) begin
         ram[i]    = 32'h9E37_79B9 * i;
         shadow[i] = 32'h9E37_79B9 * i;
      end
      ram[17'h10]    = 32'h1234_5678;
      shadow[17'h10] = 32'h1234_5678;

      repeat (2) @(posedge clock);
      model_step();
      #1;
      cycle();
      reset = 0;
      cycle();

      chk("rst_owner",  owner, 0);
      chk("rst_locked", locked, 0);
      chk("rst_ack0",   ack0, 0);
      chk("rst_maddr",  mem_address, 0);
      chk("rst_mwdata", mem_wdata, 0);

      // single read
      a1_before = a1_cnt;
      req0 = 1; wr0 = 0; lock0 = 0; addr0 = 17'h10;
      cycle();
      chk("rd_lat", sa0, 0);
      cycle();
      chk("rd_ack",  sa0, 1);
      chk("rd_data", s_rdata, 32'h1234_5678);
      req0 = 0;
      cycle();
      chk("rd_once", sa0, 0);
      chk("rd_no_ack1", a1_cnt - a1_before, 0);

      // single write
      req1 = 1; wr1 = 1; lock1 = 0; addr1 = 17'h100; wdata1 = 32'h0001_0001;
      wait_ack(1, 10, "wr");
      chk("wr_we", s_we, 1);
      req1 = 0; wr1 = 0;
      chk("wr_ram", ram[17'h100], 32'h0001_0001);
      cycle();

      // contention
      ack_log.delete();
      log_en = 1;
      req0 = 1; wr0 = 0; addr0 = 17'h1;
      req1 = 1; wr1 = 0; addr1 = 17'h2;
      n = 0;
      while (ack_log.size() < 4 && n < 40) begin
         cycle();
         n++;
         if (sa0) addr0 = addr0 + 1;
         if (sa1) addr1 = addr1 + 1;
      end
      req0 = 0; req1 = 0; log_en = 0;
      order = 4'bxxxx;
      for (int i = 0; i < 4 && i < ack_log.size(); i++)
         order[3-i] = ack_log[i][0];
      chk("contend_cnt", ack_log.size(), 4);
      chk("contend_order", order, CONT_EXP);
      cycle(); cycle();

      // lock: port 1 read-modify-write with port 0 waiting
      ack_log.delete();
      log_en = 1;
      req1 = 1; wr1 = 0; lock1 = 1; addr1 = 17'h10;
      cycle();
      req0 = 1; wr0 = 0; lock0 = 0; addr0 = 17'h33;
      wait_ack(1, 10, "lk_rd");
      wr1 = 1; lock1 = 0; addr1 = 17'h11; wdata1 = 32'hCAFE_F00D;
      held = 1; n = 0;
      do begin
         cycle();
         n++;
         held = held & s_locked;
      end while (!sa1 && n < 10);
      chk("lk_wr_ack", sa1, 1);
      chk("lk_held", held, 1);
      req1 = 0; wr1 = 0;
      wait_ack(0, 10, "lk_cpu");
      req0 = 0;
      log_en = 0;
      lk_order = 3'bxxx;
      for (int i = 0; i < 3 && i < ack_log.size(); i++)
         lk_order[2-i] = ack_log[i][0];
      chk("lk_order", lk_order, 3'b110);
      chk("lk_ram", ram[17'h11], 32'hCAFE_F00D);
      cycle();

      // reset during a write grant
      old = ram[17'h20];
      req0 = 1; wr0 = 1; lock0 = 0; addr0 = 17'h20; wdata0 = 32'hDEAD_BEEF;
      cycle();
      reset = 1;
      cycle();
      chk("rstw_ack0", sa0, 0);
      chk("rstw_we", s_we, 0);
      reset = 0; req0 = 0; wr0 = 0;
      cycle();
      chk("rstw_idle_ack", sa0, 0);
      chk("rstw_ram", ram[17'h20], old);
      chk("rstw_maddr", mem_address, 0);

      // idle
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("idle_quiet", {s_we, sa0, sa1}, 3'b000);
      end

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if (!req0 || sa0) begin
            if ($urandom_range(0, 2) != 0) begin
               req0 = 1; wr0 = 1'($urandom_range(0, 1));
               lock0 = ($urandom_range(0, 3) == 0);
               addr0 = 17'($urandom_range(0, 63)); wdata0 = $urandom;
            end else req0 = 0;
         end
         if (!req1 || sa1) begin
            if ($urandom_range(0, 2) != 0) begin
               req1 = 1; wr1 = 1'($urandom_range(0, 1));
               lock1 = ($urandom_range(0, 3) == 0);
               addr1 = 17'($urandom_range(0, 63)); wdata1 = $urandom;
            end else req1 = 0;
         end
         reset = ($urandom_range(0, 299) == 0);
         cycle();
      end
      reset = 0;
      cycle();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
